// File: rtl/multi_channel_convolution.sv
// -----------------------------------------------------------------------------
// multi_channel_convolution
//
// Valid-region 2-D convolution over `channels` input planes, summing every
// channel into a single output feature map, with a configurable stride.
// Image pixels are fetched through an external synchronous-read memory
// (data returns one cycle after the read strobe). Coefficients live in an
// internal register file that can be written while the engine is idle.
// Each accumulated result is arithmetically shifted, saturated to dataWidth,
// optionally clamped at zero (ReLU), and offered on a valid/ready stream.
//
// Ports
//   clk               rising-edge clock
//   reset             asynchronous, active-high reset
//   startConvolution  start pulse, only looked at while idle
//   reluEnable        captured at start; 1 clamps negative results to 0
//   filterWe          coefficient write strobe (idle only)
//   filterAddr        coefficient index ch*FR*FC + fr*FC + fc
//   filterDataIn      signed coefficient
//   imageAddr         image read address ch*IR*IC + r*IC + c
//   imageRe           image read strobe
//   imageDataIn       signed image data, valid the cycle after imageRe
//   write_data_output signed output pixel
//   convDone_         output valid
//   outReady          downstream ready
//   busy              engine is not idle
//   fullConvDone_out  one-cycle pulse after the final output handshake
//
// accWidth must exceed dataWidth + filterDataWidth.
// -----------------------------------------------------------------------------
module multi_channel_convolution #(
    parameter int imageRow           = 8,
    parameter int imageColumn        = 8,
    parameter int filterRow          = 3,
    parameter int filterColumn       = 3,
    parameter int channels           = 2,
    parameter int stride             = 1,
    parameter int imageAddressWidth  = 16,
    parameter int filterAddressWidth = 5,
    parameter int dataWidth          = 16,
    parameter int filterDataWidth    = 4,
    parameter int accWidth           = 28,
    parameter int outShift           = 0
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 startConvolution,
    input  logic                                 reluEnable,
    input  logic                                 filterWe,
    input  logic        [filterAddressWidth-1:0] filterAddr,
    input  logic signed [filterDataWidth-1:0]    filterDataIn,
    output logic        [imageAddressWidth-1:0]  imageAddr,
    output logic                                 imageRe,
    input  logic signed [dataWidth-1:0]          imageDataIn,
    output logic signed [dataWidth-1:0]          write_data_output,
    output logic                                 convDone_,
    input  logic                                 outReady,
    output logic                                 busy,
    output logic                                 fullConvDone_out
);

    localparam int OUT_ROW    = (imageRow - filterRow) / stride + 1;
    localparam int OUT_COL    = (imageColumn - filterColumn) / stride + 1;
    localparam int K_LEN      = filterRow * filterColumn * channels;
    localparam int PROD_W     = dataWidth + filterDataWidth;
    localparam int COEF_DEPTH = 2 ** filterAddressWidth;

    typedef logic [imageAddressWidth-1:0]  addr_t;
    typedef logic [filterAddressWidth-1:0] kidx_t;

    localparam addr_t PLANE_A   = addr_t'(imageRow * imageColumn);
    localparam addr_t IMG_COL_A = addr_t'(imageColumn);
    localparam addr_t STRIDE_A  = addr_t'(stride);
    localparam addr_t FC_LAST   = addr_t'(filterColumn - 1);
    localparam addr_t FR_LAST   = addr_t'(filterRow - 1);
    localparam addr_t CH_LAST   = addr_t'(channels - 1);
    localparam addr_t OC_LAST   = addr_t'(OUT_COL - 1);
    localparam addr_t OR_LAST   = addr_t'(OUT_ROW - 1);
    localparam kidx_t K_LAST    = kidx_t'(K_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MAC   = 3'd1,
        S_DRAIN = 3'd2,
        S_OUT   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Clamp to the signed dataWidth range.
    function automatic logic signed [dataWidth-1:0] saturate(
        input logic signed [accWidth-1:0] value
    );
        logic signed [accWidth-1:0]  max_v;
        logic signed [accWidth-1:0]  min_v;
        logic signed [dataWidth-1:0] res;
        max_v = {{(accWidth-dataWidth+1){1'b0}}, {(dataWidth-1){1'b1}}};
        min_v = ~max_v;
        if (value > max_v) begin
            res = max_v[dataWidth-1:0];
        end else if (value < min_v) begin
            res = min_v[dataWidth-1:0];
        end else begin
            res = value[dataWidth-1:0];
        end
        return res;
    endfunction

    function automatic logic signed [dataWidth-1:0] apply_relu(
        input logic signed [dataWidth-1:0] value,
        input logic                        enable
    );
        logic signed [dataWidth-1:0] res;
        res = value;
        if (enable && value[dataWidth-1]) begin
            res = '0;
        end
        return res;
    endfunction

    function automatic logic signed [dataWidth-1:0] post_process(
        input logic signed [accWidth-1:0] acc,
        input logic                       relu
    );
        logic signed [accWidth-1:0] shifted;
        shifted = acc >>> outShift;
        return apply_relu(saturate(shifted), relu);
    endfunction

    // Control state
    state_t r_state;
    state_t w_next;

    // Kernel tap and output position counters
    kidx_t r_k;
    addr_t r_fc;
    addr_t r_fr;
    addr_t r_ch;
    addr_t r_orow;
    addr_t r_ocol;

    logic  r_relu;
    addr_t r_addr_hold;

    // Coefficient register file (never reset)
    logic signed [filterDataWidth-1:0] r_coef_mem [COEF_DEPTH];

    // Stage p1: coefficient aligned with the returning image word
    logic signed [filterDataWidth-1:0] r_coef_p1;
    logic                              r_vld_p1;

    logic signed [accWidth-1:0]  r_acc;
    logic signed [dataWidth-1:0] r_out;

    logic                        w_last_tap;
    logic                        w_last_pix;
    addr_t                       w_row;
    addr_t                       w_col;
    addr_t                       w_addr;
    logic signed [PROD_W-1:0]    w_prod;
    logic signed [accWidth-1:0]  w_prod_ext;
    logic signed [accWidth-1:0]  w_acc_sum;

    assign w_last_tap = (r_k == K_LAST);
    assign w_last_pix = (r_orow == OR_LAST) && (r_ocol == OC_LAST);

    assign w_row  = r_orow * STRIDE_A + r_fr;
    assign w_col  = r_ocol * STRIDE_A + r_fc;
    assign w_addr = r_ch * PLANE_A + w_row * IMG_COL_A + w_col;

    // The product of the previous cycle's read is folded in only when that
    // cycle actually issued a read.
    assign w_prod     = imageDataIn * r_coef_p1;
    assign w_prod_ext = {{(accWidth-PROD_W){w_prod[PROD_W-1]}}, w_prod};
    assign w_acc_sum  = r_vld_p1 ? (r_acc + w_prod_ext) : r_acc;

    assign busy              = (r_state != S_IDLE);
    assign imageRe           = (r_state == S_MAC);
    assign convDone_         = (r_state == S_OUT);
    assign fullConvDone_out  = (r_state == S_DONE);
    assign write_data_output = r_out;
    // Address is live while reading, otherwise frozen at the last one issued.
    assign imageAddr         = imageRe ? w_addr : r_addr_hold;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (startConvolution) begin
                    w_next = S_MAC;
                end
            end
            S_MAC: begin
                if (w_last_tap) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_next = S_OUT;
            end
            S_OUT: begin
                if (outReady) begin
                    w_next = w_last_pix ? S_DONE : S_MAC;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Coefficient writes are accepted only while idle, including the cycle
    // that samples startConvolution.
    always_ff @(posedge clk) begin
        if (filterWe && (r_state == S_IDLE)) begin
            r_coef_mem[filterAddr] <= filterDataIn;
        end
    end

    // Stage p0 -> p1: fetch the coefficient for the tap being read now.
    always_ff @(posedge clk) begin
        r_coef_p1 <= r_coef_mem[r_k];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld_p1    <= 1'b0;
            r_acc       <= '0;
            r_out       <= '0;
            r_relu      <= 1'b0;
            r_k         <= '0;
            r_fc        <= '0;
            r_fr        <= '0;
            r_ch        <= '0;
            r_orow      <= '0;
            r_ocol      <= '0;
            r_addr_hold <= '0;
        end else begin
            r_vld_p1 <= (r_state == S_MAC);
            case (r_state)
                S_IDLE: begin
                    if (startConvolution) begin
                        r_relu <= reluEnable;
                        r_acc  <= '0;
                        r_k    <= '0;
                        r_fc   <= '0;
                        r_fr   <= '0;
                        r_ch   <= '0;
                        r_orow <= '0;
                        r_ocol <= '0;
                    end
                end
                S_MAC: begin
                    r_acc       <= w_acc_sum;
                    r_addr_hold <= w_addr;
                    r_k         <= w_last_tap ? '0 : r_k + 1'b1;
                    // fc fastest, then fr, then ch
                    if (r_fc == FC_LAST) begin
                        r_fc <= '0;
                        if (r_fr == FR_LAST) begin
                            r_fr <= '0;
                            r_ch <= (r_ch == CH_LAST) ? '0 : r_ch + 1'b1;
                        end else begin
                            r_fr <= r_fr + 1'b1;
                        end
                    end else begin
                        r_fc <= r_fc + 1'b1;
                    end
                end
                S_DRAIN: begin
                    // Last product lands here; the finished sum is
                    // post-processed on the way into OUT.
                    r_acc <= w_acc_sum;
                    r_out <= post_process(w_acc_sum, r_relu);
                end
                S_OUT: begin
                    if (outReady && !w_last_pix) begin
                        r_acc <= '0;
                        if (r_ocol == OC_LAST) begin
                            r_ocol <= '0;
                            r_orow <= r_orow + 1'b1;
                        end else begin
                            r_ocol <= r_ocol + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multi_channel_convolution.sv
module tb_multi_channel_convolution;

    localparam int IR    = 8;
    localparam int IC    = 8;
    localparam int FR    = 3;
    localparam int FC    = 3;
    localparam int CH    = 2;
    localparam int STR   = 1;
    localparam int SHIFT = 0;
    localparam int OR_N  = (IR - FR) / STR + 1;
    localparam int OC_N  = (IC - FC) / STR + 1;
    localparam int NOUT  = OR_N * OC_N;
    localparam int K     = FR * FC * CH;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // Main instance (default parameters)
    logic               start, relu, fwe, ordy;
    logic [4:0]         faddr;
    logic signed [3:0]  fdata;
    logic [15:0]        iaddr;
    logic               ire;
    logic signed [15:0] idata;
    logic signed [15:0] dout;
    logic               cdone, busy, fdone;

    // Stride-2 instance
    logic               s_start, s_relu, s_fwe, s_ordy;
    logic [4:0]         s_faddr;
    logic signed [3:0]  s_fdata;
    logic [15:0]        s_iaddr;
    logic               s_ire;
    logic signed [15:0] s_idata;
    logic signed [15:0] s_dout;
    logic               s_cdone, s_busy, s_fdone;

    multi_channel_convolution u_dut (
        .clk(clk), .reset(reset), .startConvolution(start), .reluEnable(relu),
        .filterWe(fwe), .filterAddr(faddr), .filterDataIn(fdata),
        .imageAddr(iaddr), .imageRe(ire), .imageDataIn(idata),
        .write_data_output(dout), .convDone_(cdone), .outReady(ordy),
        .busy(busy), .fullConvDone_out(fdone)
    );

    multi_channel_convolution #(
        .imageRow(5), .imageColumn(5), .channels(1), .stride(2)
    ) u_str (
        .clk(clk), .reset(reset), .startConvolution(s_start), .reluEnable(s_relu),
        .filterWe(s_fwe), .filterAddr(s_faddr), .filterDataIn(s_fdata),
        .imageAddr(s_iaddr), .imageRe(s_ire), .imageDataIn(s_idata),
        .write_data_output(s_dout), .convDone_(s_cdone), .outReady(s_ordy),
        .busy(s_busy), .fullConvDone_out(s_fdone)
    );

    // Synchronous-read image memories
    logic signed [15:0] mem   [0:CH*IR*IC-1];
    logic signed [15:0] s_mem [0:24];
    always @(posedge clk) if (ire)   idata   <= mem[iaddr[6:0]];
    always @(posedge clk) if (s_ire) s_idata <= s_mem[s_iaddr[4:0]];

    // Reference data
    int img [CH][IR][IC];
    int cf  [CH][FR][FC];
    int exp_q[$];

    int n_cmp  = 0;
    int n_fail = 0;
    int hs_cnt = 0;
    int done_cnt = 0;
    bit chk_en = 0;
    bit prev_stall = 0;
    logic signed [15:0] prev_val;

    task automatic check(input string name, input longint act, input longint expv);
        n_cmp++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    // Straight-from-the-definition convolution of the reference arrays.
    task automatic build_expected(input bit rl);
        int acc;
        exp_q.delete();
        for (int orow = 0; orow < OR_N; orow++) begin
            for (int ocol = 0; ocol < OC_N; ocol++) begin
                acc = 0;
                for (int c = 0; c < CH; c++)
                    for (int r = 0; r < FR; r++)
                        for (int k = 0; k < FC; k++)
                            acc += img[c][orow*STR+r][ocol*STR+k] * cf[c][r][k];
                acc = acc >>> SHIFT;
                if (acc > 32767) acc = 32767;
                if (acc < -32768) acc = -32768;
                if (rl && acc < 0) acc = 0;
                exp_q.push_back(acc);
            end
        end
    endtask

    task automatic sync_mem();
        for (int c = 0; c < CH; c++)
            for (int r = 0; r < IR; r++)
                for (int k = 0; k < IC; k++)
                    mem[c*IR*IC + r*IC + k] = 16'(img[c][r][k]);
    endtask

    task automatic fill_img(input int mode);
        for (int c = 0; c < CH; c++)
            for (int r = 0; r < IR; r++)
                for (int k = 0; k < IC; k++)
                    case (mode)
                        0: img[c][r][k] = 1;
                        1: img[c][r][k] = ((c*7 + r*3 + k*5) % 11) - 5;
                        default: img[c][r][k] = 32767;
                    endcase
        sync_mem();
    endtask

    task automatic set_cf(input int ch, input int val, input bit pattern);
        for (int r = 0; r < FR; r++)
            for (int k = 0; k < FC; k++)
                cf[ch][r][k] = pattern ? ((ch*5 + r*3 + k) % 15) - 7 : val;
    endtask

    task automatic load_coefs();
        for (int c = 0; c < CH; c++)
            for (int r = 0; r < FR; r++)
                for (int k = 0; k < FC; k++) begin
                    @(posedge clk); #1;
                    fwe = 1'b1; faddr = 5'(c*FR*FC + r*FC + k); fdata = 4'(cf[c][r][k]);
                end
        @(posedge clk); #1;
        fwe = 1'b0;
    endtask

    // Compare process: every handshake against the model, plus stream rules.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en && !reset) begin
                if (prev_stall) begin
                    check("stall_valid", cdone, 1);
                    check("stall_data", dout, prev_val);
                end
                if (cdone) check("re_while_out", ire, 0);
                if (cdone && ordy) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_fail++;
                        $display("FAIL extra_pixel: got %0d with no pixel outstanding", dout);
                    end else begin
                        check($sformatf("pixel%0d", hs_cnt), dout, exp_q.pop_front());
                    end
                    hs_cnt++;
                end
                if (fdone) done_cnt++;
                prev_stall = cdone && !ordy;
                prev_val   = dout;
            end else begin
                prev_stall = 0;
            end
        end
    end

    task automatic start_run(input bit rl, input int wa, input int wd);
        @(posedge clk); #1;
        start = 1'b1; relu = rl;
        if (wa >= 0) begin fwe = 1'b1; faddr = 5'(wa); fdata = 4'(wd); end
        @(posedge clk); #1;
        start = 1'b0; fwe = 1'b0; relu = 1'b0;
    endtask

    task automatic wait_done(output int n);
        bit got;
        got = 0; n = 0;
        while (!got && n < 3000) begin
            @(negedge clk); n++;
            if (fdone === 1'b1) got = 1;
        end
        check("done_seen", got, 1);
    endtask

    task automatic wait_hs(input int target);
        int n;
        n = 0;
        while (hs_cnt < target && n < 2000) begin @(posedge clk); #1; n++; end
        check("hs_wait", (hs_cnt >= target) ? 1 : 0, 1);
    endtask

    // One full run. wa>=0 writes coefficient wa in the start cycle.
    task automatic run_full(input bit rl, input int wa, input int wd,
                            input bit do_pin, input int pin, input bit bp);
        int n, m;
        if (wa >= 0) cf[wa/(FR*FC)][(wa%(FR*FC))/FC][wa%FC] = wd;
        build_expected(rl);
        if (do_pin) check("model_pin", exp_q[0], pin);
        hs_cnt = 0; done_cnt = 0;
        start_run(rl, wa, wd);
        if (bp) begin
            wait_hs(2);
            ordy = 1'b0;
            m = 0;
            while (!cdone && m < 100) begin @(posedge clk); #1; m++; end
            check("bp_reach_out", cdone, 1);
            // Attempt a restart and a coefficient overwrite while busy.
            start = 1'b1; fwe = 1'b1; faddr = 5'd0; fdata = -4'sd8;
            @(posedge clk); #1;
            start = 1'b0; fwe = 1'b0;
            repeat (4) begin @(posedge clk); #1; end
            ordy = 1'b1;
        end
        wait_done(n);
        if (!bp) check("cycles", n, NOUT*(K+2)+1);
        repeat (2) @(posedge clk);
        #1;
        check("done_pulses", done_cnt, 1);
        check("pixel_count", hs_cnt, NOUT);
        check("pixels_left", exp_q.size(), 0);
        check("busy_after", busy, 0);
    endtask

    initial begin
        int s_exp [4];
        int s_got [$];
        int n;
        s_exp = '{54, 72, 144, 162};
        reset = 1'b1;
        start = 0; relu = 0; fwe = 0; faddr = '0; fdata = '0; ordy = 1'b1;
        s_start = 0; s_relu = 0; s_fwe = 0; s_faddr = '0; s_fdata = '0; s_ordy = 1'b1;
        for (int i = 0; i < CH*IR*IC; i++) mem[i] = '0;
        for (int i = 0; i < 25; i++) s_mem[i] = 16'(i);
        @(posedge clk); @(posedge clk); #1;

        // Reset state
        check("rst_busy", busy, 0);
        check("rst_re", ire, 0);
        check("rst_valid", cdone, 0);
        check("rst_fdone", fdone, 0);
        check("rst_data", dout, 0);
        check("rst_addr", iaddr, 0);
        check("rst_s_busy", s_busy, 0);
        check("rst_s_data", s_dout, 0);
        reset = 1'b0;
        chk_en = 1'b1;

        // Stride 2 on 5x5, pixel = r*5+c, all-ones 3x3 kernel
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            s_fwe = 1'b1; s_faddr = 5'(i); s_fdata = 4'sd1;
        end
        @(posedge clk); #1;
        s_fwe = 1'b0; s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        n = 0;
        while (n < 500) begin
            @(negedge clk); n++;
            if (s_cdone && s_ordy) s_got.push_back(int'(s_dout));
            if (s_fdone) break;
        end
        check("s_cycles", n, 4*(9+2)+1);
        check("s_count", s_got.size(), 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("s_pixel%0d", i), (i < s_got.size()) ? s_got[i] : -1, s_exp[i]);

        // All ones, two channels
        fill_img(0); set_cf(0, 1, 0); set_cf(1, 1, 0); load_coefs();
        run_full(0, -1, 0, 1, 18, 0);
        // Channel 1 negated cancels channel 0
        set_cf(1, -1, 0); load_coefs();
        run_full(0, -1, 0, 1, 0, 0);
        // All -1 coefficients, without and with ReLU
        set_cf(0, -1, 0); load_coefs();
        run_full(0, -1, 0, 1, -18, 0);
        run_full(1, -1, 0, 1, 0, 0);
        // Saturation high and low
        fill_img(2); set_cf(0, 7, 0); set_cf(1, 7, 0); load_coefs();
        run_full(0, -1, 0, 1, 32767, 0);
        set_cf(0, -8, 0); set_cf(1, -8, 0); load_coefs();
        run_full(0, -1, 0, 1, -32768, 0);
        run_full(1, -1, 0, 1, 0, 0);
        // Mixed-sign pattern; second run also writes a coefficient with start
        fill_img(1); set_cf(0, 0, 1); set_cf(1, 0, 1); load_coefs();
        run_full(0, -1, 0, 0, 0, 0);
        run_full(1, 4, -8, 0, 0, 0);
        // Backpressure on pixel 2, with ignored start/write while busy
        run_full(0, -1, 0, 0, 0, 1);

        // Reset during pixel 3, then a clean rerun
        build_expected(0);
        hs_cnt = 0; done_cnt = 0;
        start_run(0, -1, 0);
        wait_hs(3);
        repeat (4) begin @(posedge clk); #1; end
        reset = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_re", ire, 0);
        check("abort_valid", cdone, 0);
        check("abort_data", dout, 0);
        check("abort_addr", iaddr, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("abort_no_done", done_cnt, 0);
        check("abort_idle", busy, 0);
        exp_q.delete();
        run_full(0, -1, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_channel_convolution.md
Name: multi_channel_convolution

Overview:
- Parametrised successor to the single-channel convolution engine.
- Computes a valid-region 2-D convolution over C input channels, summing all channels into one output feature map, with configurable stride.
- Adds an output post-processing stage (arithmetic shift, signed saturation, optional ReLU) and a valid/ready output stream with backpressure.
- Reads image data through an external synchronous-read memory port. Holds filter coefficients in an internal register file loaded over a write port. Sits between the image buffer and the pooling/next layer.

Parameters:
- imageRow, 8, input image rows
- imageColumn, 8, input image columns
- filterRow, 3, kernel rows
- filterColumn, 3, kernel columns
- channels, 2, input channel count (>=1)
- stride, 1, row and column step (>=1)
- imageAddressWidth, 16, image memory address width
- filterAddressWidth, 5, filter register file address width (2^w >= filterRow*filterColumn*channels)
- dataWidth, 16, signed image and output width
- filterDataWidth, 4, signed coefficient width
- accWidth, 28, signed accumulator width
- outShift, 0, arithmetic right shift applied to the accumulator before saturation

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- startConvolution  in  1  start pulse; sampled only in IDLE
- reluEnable  in  1  sampled at start; 1 = clamp negative results to 0
- filterWe  in  1  filter write strobe
- filterAddr  in  filterAddressWidth  coefficient index, ch*filterRow*filterColumn + fr*filterColumn + fc
- filterDataIn  in  filterDataWidth  signed coefficient
- imageAddr  out  imageAddressWidth  read address, ch*imageRow*imageColumn + r*imageColumn + c
- imageRe  out  1  read enable
- imageDataIn  in  dataWidth  signed read data, valid exactly one cycle after imageRe
- write_data_output  out  dataWidth  signed output pixel
- convDone_  out  1  output valid
- outReady  in  1  downstream ready
- busy  out  1  high in every state except IDLE
- fullConvDone_out  out  1  one-cycle pulse after the final output handshake

Behaviour:
- Output dimensions: outRow = (imageRow-filterRow)/stride+1 and outCol = (imageColumn-filterColumn)/stride+1, using integer division. Pixels are emitted in raster order (row-major).
- Reset values: all outputs 0; state IDLE; accumulator, counters and post-processing registers 0.
- The filter register file is not reset.
- filterWe is honoured only in IDLE and ignored otherwise. A write in the same cycle as startConvolution is honoured, and the written coefficient is used.
- States:
  - IDLE: on startConvolution go to MAC; latch reluEnable; clear accumulator and kernel counters.
  - MAC: issue one read per cycle, iterating fc fastest, then fr, then ch. Kernel length is K = filterRow*filterColumn*channels. The product imageDataIn*coef (sign-extended to accWidth) is added to the accumulator one cycle after each read. After the K-th read go to DRAIN.
  - DRAIN: one cycle; perform the final MAC.
  - OUT: present the result with convDone_=1. If outReady=1, the handshake completes that cycle. Then either advance the output position and return to MAC with the accumulator cleared, or, if this was the last pixel, go to DONE.
  - DONE: one cycle with fullConvDone_out=1; then IDLE.
- Cycle budget per pixel is K+2 with outReady held high. Total run is outRow*outCol*(K+2)+1 cycles from the start-sample edge to the fullConvDone_out pulse.
- Post-processing:
  - acc >>> outShift.
  - Saturate to [-2^(dataWidth-1), 2^(dataWidth-1)-1].
  - If relu is latched, values <0 become 0.
  - The result is registered on entry to OUT.
- Backpressure: while in OUT with outReady=0, write_data_output and convDone_ hold stable and no reads are issued.
- startConvolution while busy is ignored.
- imageRe is 0 outside MAC. imageAddr holds its last value when imageRe is 0.
- Reset asserted mid-operation: outputs go to their reset values and the state returns to IDLE immediately. No fullConvDone_out pulse is produced.
- Stride that does not divide evenly: trailing rows and columns that cannot hold a full kernel are skipped.

Test Plan:
- 4x4 image, 3x3 filter, channels=1, stride=1, all pixels=1, all coefs=1 -> 4 outputs of 9, then fullConvDone_out exactly 4*(9+2)+1 = 45 cycles after start.
- Default 8x8, channels=2, image=1, coefs=1 -> 36 outputs of 18. Change ch1 coefs to -1 -> all outputs 0.
- 5x5, stride=2, channels=1, pixel value = r*5+c, coefs=1 -> outputs 54, 72, 144, 162 in raster order.
- Saturation and ReLU:
  - All pixels 32767, coefs 7, channels=2 -> 32767.
  - Coefs -1 with reluEnable=0 -> -18 per output (channels=2); with reluEnable=1 -> 0.
- Backpressure: outReady low for 5 cycles on pixel 2 -> value and convDone_ stable, imageRe=0 throughout, no pixel lost or duplicated, total count correct.
- Reset pulsed during MAC of pixel 3, then restart -> full correct output sequence with no stale accumulator. filterWe and startConvolution asserted while busy have no effect.
